uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_bit_timer.sv | 38 +++
 rtl/uart_tx.sv | 145 ++++++++++++++
 tb/tb_uart_tx.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding, line levels
// and parity-type encoding.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } uart_par_e;

  // Even parity is the plain XOR of the payload; odd parity inverts it.
  function automatic logic parity_bit(input logic xor_red, input logic par_typ);
    return (par_typ == PAR_ODD) ? ~xor_red : xor_red;
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period counter: counts 0..prescale-1 while running and strobes bit_done_o
// on the last cycle of each bit. A prescale of 0 is treated as 1.
module uart_tx_bit_timer #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clear_i,
  input  logic                  run_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  bit_done_o
);

  logic [PRESCALE_W-1:0] cnt_q;
  logic [PRESCALE_W-1:0] cnt_d;
  logic [PRESCALE_W-1:0] last_cnt;

  assign last_cnt   = (prescale_i == '0) ? '0 : prescale_i - PRESCALE_W'(1);
  assign bit_done_o = run_i && (cnt_q == last_cnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = bit_done_o ? '0 : cnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH payload bits LSB first, optional
// parity bit (build with UART_TX_PARITY_EN), stop bit. Line idles high.
//
// Handshake: data_valid is a single-cycle request that is accepted only when
// the FSM is in IDLE (busy=0); requests while busy are dropped, there is no
// buffering. The frame's first start-bit cycle follows the accepting cycle.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
`ifdef UART_TX_PARITY_EN
  input  logic                  par_en,
  input  logic                  par_typ,
`endif
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tx_out,
  output logic                  busy,
  output uart_state_e           dbg_state_o
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  uart_state_e           state_q;
  logic                  tx_out_q;
  logic                  busy_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [IDX_W-1:0]      bit_idx_q;
  logic [PRESCALE_W-1:0] presc_q;
  logic                  accept;
  logic                  bit_done;
`ifdef UART_TX_PARITY_EN
  logic                  par_en_q;
  logic                  par_bit_q;
`endif

  assign accept      = (state_q == ST_IDLE) && data_valid;
  assign tx_out      = tx_out_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

  uart_tx_bit_timer #(
    .PRESCALE_W (PRESCALE_W)
  ) u_bit_timer (
    .clk        (clk),
    .rstn       (rstn),
    .clear_i    (accept),
    .run_i      (busy_q),
    .prescale_i (presc_q),
    .bit_done_o (bit_done)
  );

  // The prescale, payload and parity settings are all latched at acceptance so
  // that input changes during a frame cannot disturb it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      tx_out_q  <= STOP_BIT;
      busy_q    <= 1'b0;
      data_q    <= '0;
      bit_idx_q <= '0;
      presc_q   <= '0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (data_valid) begin
            data_q    <= p_data;
            presc_q   <= prescale;
            bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= par_en;
            par_bit_q <= parity_bit(^p_data, par_typ);
`endif
            state_q   <= ST_START;
            tx_out_q  <= START_BIT;
            busy_q    <= 1'b1;
          end
        end

        ST_START: begin
          if (bit_done) begin
            state_q  <= ST_DATA;
            tx_out_q <= data_q[0];
          end
        end

        ST_DATA: begin
          if (bit_done) begin
            if (bit_idx_q == LAST_IDX) begin
              bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
              if (par_en_q) begin
                state_q  <= ST_PARITY;
                tx_out_q <= par_bit_q;
              end else begin
                state_q  <= ST_STOP;
                tx_out_q <= STOP_BIT;
              end
`else
              state_q  <= ST_STOP;
              tx_out_q <= STOP_BIT;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + IDX_W'(1);
              data_q    <= data_q >> 1;
              tx_out_q  <= data_q[1];
            end
          end
        end

        ST_PARITY: begin
          if (bit_done) begin
            state_q  <= ST_STOP;
            tx_out_q <= STOP_BIT;
          end
        end

        ST_STOP: begin
          if (bit_done) begin
            state_q  <= ST_IDLE;
            tx_out_q <= STOP_BIT;
            busy_q   <= 1'b0;
          end
        end

        default: begin
          state_q  <= ST_IDLE;
          tx_out_q <= STOP_BIT;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed frames plus randomized frames checked cycle by
// cycle against a bit-list model of the serial line.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int DW = 8;
  localparam int PW = 6;

  logic          clk;
  logic          rstn;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          par_en;
  logic          par_typ;
  logic [PW-1:0] prescale;
  logic          tx_out;
  logic          busy;
  uart_state_e   dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  logic [1:0] exp_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx #(
    .DATA_WIDTH (DW),
    .PRESCALE_W (PW)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .p_data      (p_data),
    .data_valid  (data_valid),
`ifdef UART_TX_PARITY_EN
    .par_en      (par_en),
    .par_typ     (par_typ),
`endif
    .prescale    (prescale),
    .tx_out      (tx_out),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: the frame as a list of line levels, each held max(prescale,1) cycles.
  task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt,
                           input int psc, input bit pulse, input bit rst_bit3);
    logic bits_q[$];
    int   p;
    int   n;
    int   idx;
    int   busy_cnt;
    int   pulse_at;
    int   rst_at;
    logic pe_eff;
    logic [1:0] e;
`ifdef UART_TX_PARITY_EN
    pe_eff = pe;
`else
    pe_eff = 1'b0;
`endif
    p = (psc == 0) ? 1 : psc;
    bits_q.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits_q.push_back(d[i]);
    if (pe_eff) bits_q.push_back((($countones(d) % 2) == 1) ^ pt);
    bits_q.push_back(1'b1);
    exp_q.delete();
    foreach (bits_q[i]) for (int k = 0; k < p; k++) exp_q.push_back({1'b1, bits_q[i]});
    n        = exp_q.size();
    pulse_at = pulse ? n / 2 : -1;
    rst_at   = rst_bit3 ? p * 4 + p / 2 : -1;

    // driver
    @(posedge clk); #1;
    p_data = d; prescale = PW'(psc); par_en = pe; par_typ = pt; data_valid = 1'b1;
    @(posedge clk); #1;
    data_valid = 1'b0;
    p_data = DW'($urandom); prescale = PW'($urandom);
    par_en = 1'($urandom); par_typ = 1'($urandom);

    idx = 0;
    busy_cnt = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check("line{busy,tx}", {30'd0, busy, tx_out}, {30'd0, e});
      busy_cnt += int'(busy);
      if (idx == pulse_at) begin
        data_valid = 1'b1;
        p_data = 8'h3C;
      end else begin
        data_valid = 1'b0;
      end
      if (idx == rst_at) begin
        rstn = 1'b0;
        #1;
        check("rst_tx", {31'd0, tx_out}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        exp_q.delete();
        data_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("post_rst_idle", {30'd0, busy, tx_out}, 32'd1);
        end
        return;
      end
      idx++;
    end
    data_valid = 1'b0;
    @(negedge clk);
    check("idle_after", {30'd0, busy, tx_out}, 32'd1);
    check("busy_len", busy_cnt, p * (DW + 2 + int'(pe_eff)));
  endtask

  initial begin
    rstn = 1'b0;
    p_data = '0; data_valid = 1'b0; par_en = 1'b0; par_typ = 1'b0; prescale = '0;
    repeat (3) @(negedge clk);
    check("reset_tx", {31'd0, tx_out}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    rstn = 1'b1;

    run_frame(8'hA5, 1'b1, 1'b0, 8, 1'b0, 1'b0);
    run_frame(8'hA5, 1'b1, 1'b1, 8, 1'b0, 1'b0);
    run_frame(8'hFF, 1'b0, 1'b0, 4, 1'b0, 1'b0);
    run_frame(8'h01, 1'b1, 1'b0, 1, 1'b0, 1'b0);
    run_frame(8'h01, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    run_frame(8'h5A, 1'b1, 1'b1, 3, 1'b1, 1'b0);
    run_frame(8'h96, 1'b0, 1'b0, 4, 1'b0, 1'b1);
    run_frame(8'hC3, 1'b1, 1'b0, 2, 1'b0, 1'b0);
    run_frame(8'h6E, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    run_frame(8'h00, 1'b1, 1'b1, 2, 1'b0, 1'b0);

    for (int t = 0; t < 20; t++) begin
      run_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 9),
                bit'($urandom_range(0, 1)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
